rr_scale_mux: RTL

Parametrised N-channel, WIDTH-bit registered multiplexer with per-channel valid/ready handshakes, successor to the two-input combinational scale mux. It selects one source per cycle, either by an explicit select (fixed mode) or by round-robin arbitration among valid sources. The selected word is captured into a single output register stage. It sits between multiple producers (register file read ports, ALU/memory result sources) and a single consumer on the CPU datapath.

---
 rtl/rr_scale_mux.sv | 100 ++++++++++
 1 files changed

// File: rtl/rr_scale_mux.sv
// N-channel registered multiplexer with per-channel valid/ready handshakes.
// Grant comes from an explicit select (mode=0) or from round-robin arbitration (mode=1).
module rr_scale_mux #(
    parameter int WIDTH = 8,
    parameter int SELW  = 2
) (
    input  logic                      clk,
    input  logic                      rst_,
    input  logic [(2**SELW)*WIDTH-1:0] in_data,
    input  logic [(2**SELW)-1:0]      in_valid,
    output logic [(2**SELW)-1:0]      in_ready,
    input  logic                      mode,
    input  logic [SELW-1:0]           sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [SELW-1:0]           out_ch,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam int CH = 2**SELW;

    logic              grant_s;
    logic [SELW-1:0]   gidx_s;
    logic              load_s;
    logic [CH-1:0]     in_ready_s;
    logic [WIDTH-1:0]  gdata_s;
    logic [SELW-1:0]   ptr_r;
    logic [WIDTH-1:0]  out_data_r;
    logic [SELW-1:0]   out_ch_r;
    logic              out_valid_r;

    // Grant selection: fixed select or first valid channel at or after ptr.
    always_comb begin
        grant_s = 1'b0;
        gidx_s  = '0;
        if (mode == 1'b0) begin
            if (in_valid[sel]) begin
                grant_s = 1'b1;
                gidx_s  = sel;
            end else begin
                grant_s = 1'b0;
                gidx_s  = '0;
            end
        end else begin
            // Descending scan so the closest channel to ptr is written last and wins.
            for (int k = CH - 1; k >= 0; k--) begin
                if (in_valid[ptr_r + SELW'(k)]) begin
                    grant_s = 1'b1;
                    gidx_s  = ptr_r + SELW'(k);
                end else begin
                    grant_s = grant_s;
                    gidx_s  = gidx_s;
                end
            end
        end
    end

    // No word is accepted while reset is asserted.
    assign load_s  = rst_ && (!out_valid_r || out_ready) && grant_s;
    assign gdata_s = in_data[gidx_s*WIDTH +: WIDTH];

    // One-hot ready to the granted channel only when the output stage can take it.
    always_comb begin
        in_ready_s = '0;
        if (load_s) begin
            in_ready_s[gidx_s] = 1'b1;
        end else begin
            in_ready_s = '0;
        end
    end

    // Output register stage and round-robin pointer.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            out_data_r  <= '0;
            out_ch_r    <= '0;
            out_valid_r <= 1'b0;
            ptr_r       <= '0;
        end else if (load_s) begin
            out_data_r  <= gdata_s;
            out_ch_r    <= gidx_s;
            out_valid_r <= 1'b1;
            if (mode) begin
                ptr_r <= gidx_s + SELW'(1);
            end else begin
                ptr_r <= ptr_r;
            end
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_data  = out_data_r;
    assign out_ch    = out_ch_r;
    assign out_valid = out_valid_r;

endmodule
